ring_phase_monitor: RTL and testbench
=====================================

// Module: ring_phase_monitor
// PURPOSE
//   Consumes the one-hot count of the upstream ring_counter. Checks every clock that the
//   count is one-hot and has advanced exactly one position. Produces a binary phase index,
//   a full-rotation counter, a lock flag and an error flag for downstream control logic.
//   Sits directly after the ring counter, on the same clock.
// PARAMETERS
//   N           4   ring width; N >= 2; phase width PW = $clog2(N)
//   LOCK_STEPS  3   consecutive legal steps needed to assert lock (1..15)
//   ROT_W       4   width of the rotation counter
//   SHIFT_LEFT  1   1: legal step is next = {prev[N-2:0],prev[N-1]}; 0: rotate right
// PORTS
//   clk         in   1      rising-edge clock (same clock as the ring counter)
//   override_n  in   1      asynchronous active-low reset
//   count       in   N      one-hot ring value from the ring counter
//   clr         in   1      sync clear: rotations -> 0, releases sticky fault
//   phase       out  PW     binary index of the set bit in the last valid count
//   rotations   out  ROT_W  completed rotations while locked; wraps
//   lock        out  1      sequence verified legal
//   err         out  1      illegal value or step detected
// BEHAVIOUR
//   - Reset (override_n=0, async): phase=0, rotations=0, lock=0, err=0, state=IDLE,
//     prev=0, good_cnt=0. All outputs registered. 1-cycle latency from count to outputs.
//   - onehot = exactly one bit of count set. step_ok = onehot && count == rot(prev).
//   - phase <= index(count) on every edge where onehot; otherwise holds.
//   - prev <= count on every edge.
//   - FSM (state in {IDLE, ACQ, LOCK, FAULT}):
//     IDLE : first edge after reset. onehot -> ACQ (good_cnt=0); else -> FAULT.
//     ACQ  : step_ok -> good_cnt++; at good_cnt == LOCK_STEPS-1, go to LOCK (lock=1 on
//            the same edge). !step_ok -> FAULT.
//     LOCK : step_ok -> stay. If count[0]==1 (SHIFT_LEFT=1) or count[N-1]==1 (SHIFT_LEFT=0),
//            rotations++ (wraps 2^ROT_W-1 -> 0). !step_ok -> FAULT.
//     FAULT: err=1, lock=0, good_cnt=0. Exit rule: see CONFIGURATION.
//   - Hold (count == prev) is illegal: the ring advances every clock.
//   - count==0 or multi-hot: err on the next edge; phase holds its last valid value.
//   - clr: rotations <= 0 and has priority over a simultaneous increment. clr does not
//     affect lock or the ACQ/LOCK state.
//   - Reset mid-rotation: immediate return to the reset values; reacquires from IDLE.
// CONFIGURATION
//   STICKY_ERR_EN defined  : FAULT holds (err=1) until an edge with clr=1. On that edge,
//     onehot -> ACQ (err=0); !onehot -> stay in FAULT.
//   STICKY_ERR_EN undefined: FAULT exits on the first edge with onehot -> ACQ (err=0 on
//     that edge). clr is only the rotation clear.
// TESTING (N=4, LOCK_STEPS=3, ROT_W=4, SHIFT_LEFT=1)
//   1. Release reset; drive 0001,0010,0100,1000 on consecutive edges -> lock=1 after the
//      edge that samples 1000; phase=3; err=0; rotations=0.
//   2. Continue the legal sequence for 16 passes through 0001 -> rotations counts 1..15,
//      then wraps to 0; lock stays 1.
//   3. While locked at phase=1, drive 0011 -> next edge: err=1, lock=0, phase stays 1.
//   4. Skip a step (0001 -> 0100) -> err=1. Non-sticky: resume legal input -> err=0 on the
//      next edge, lock=1 three steps later. Sticky: err stays 1 until clr; then reacquire.
//   5. clr asserted on the same edge as a rotation increment at rotations=5 ->
//      rotations=0.
//   6. Pull override_n low mid-rotation, between edges -> phase, rotations, lock and err
//      become 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/ring_phase_monitor_if.sv
// Bus between a ring-counter consumer and ring_phase_monitor: one-hot count in,
// phase/rotation/lock/error status out.
interface ring_phase_monitor_if #(
    parameter int N     = 4,
    parameter int ROT_W = 4
);
    localparam int PW = $clog2(N);

    logic [N-1:0]     count;
    logic             clr;
    logic [PW-1:0]    phase;
    logic [ROT_W-1:0] rotations;
    logic             lock;
    logic             err;

    modport master (output count, clr, input phase, rotations, lock, err);
    modport slave  (input count, clr, output phase, rotations, lock, err);
endinterface

// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring count for legal single-position advances; reports phase,
// rotations, lock and error. Define STICKY_ERR_EN to hold faults until clr.
//
// state | meaning
// IDLE  | first edge after reset, waiting for any one-hot value
// ACQ   | counting consecutive legal steps toward lock
// LOCK  | sequence verified; rotations counted
// FAULT | illegal value or step seen; err asserted
module ring_phase_monitor #(
    parameter int N          = 4,
    parameter int LOCK_STEPS = 3,
    parameter int ROT_W      = 4,
    parameter int SHIFT_LEFT = 1
) (
    input  logic             clk,
    input  logic             override_n,
    ring_phase_monitor_if.slave bus
);
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, ACQ, LOCK, FAULT} state_t;

    state_t           state;
    logic [N-1:0]     prev;
    logic [3:0]       good_cnt;
    logic [PW-1:0]    phase_q;
    logic [ROT_W-1:0] rot_q;
    logic             lock_q;
    logic             err_q;

    logic             onehot;
    logic             step_ok;
    logic             wrap_bit;
    logic             fault_exit;
    logic [N-1:0]     expect_next;
    logic [PW-1:0]    idx;

    generate
        if (SHIFT_LEFT != 0) begin : g_left
            assign expect_next = {prev[N-2:0], prev[N-1]};
            assign wrap_bit    = bus.count[0];
        end else begin : g_right
            assign expect_next = {prev[0], prev[N-1:1]};
            assign wrap_bit    = bus.count[N-1];
        end
    endgenerate

    assign onehot  = (bus.count != '0) && ((bus.count & (bus.count - 1'b1)) == '0);
    assign step_ok = onehot && (bus.count == expect_next);

`ifdef STICKY_ERR_EN
    assign fault_exit = bus.clr && onehot;
`else
    assign fault_exit = onehot;
`endif

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.count[i]) idx = PW'(i);
        end
    end

    always_ff @(posedge clk or negedge override_n) begin
        if (!override_n) begin
            state    <= IDLE;
            prev     <= '0;
            good_cnt <= '0;
            phase_q  <= '0;
            rot_q    <= '0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev <= bus.count;
            if (onehot) phase_q <= idx;

            // clear wins over a same-edge wrap increment
            if (bus.clr)
                rot_q <= '0;
            else if (state == LOCK && step_ok && wrap_bit)
                rot_q <= rot_q + ROT_W'(1);

            case (state)
                IDLE: begin
                    good_cnt <= '0;
                    lock_q   <= 1'b0;
                    if (onehot) begin
                        state <= ACQ;
                        err_q <= 1'b0;
                    end else begin
                        state <= FAULT;
                        err_q <= 1'b1;
                    end
                end
                ACQ: begin
                    if (!step_ok) begin
                        state    <= FAULT;
                        err_q    <= 1'b1;
                        lock_q   <= 1'b0;
                        good_cnt <= '0;
                    end else if (good_cnt == 4'(LOCK_STEPS - 1)) begin
                        state  <= LOCK;
                        lock_q <= 1'b1;
                    end else begin
                        good_cnt <= good_cnt + 4'd1;
                    end
                end
                LOCK: begin
                    if (!step_ok) begin
                        state    <= FAULT;
                        err_q    <= 1'b1;
                        lock_q   <= 1'b0;
                        good_cnt <= '0;
                    end
                end
                default: begin
                    lock_q   <= 1'b0;
                    good_cnt <= '0;
                    if (fault_exit) begin
                        state <= ACQ;
                        err_q <= 1'b0;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.phase     = phase_q;
    assign bus.rotations = rot_q;
    assign bus.lock      = lock_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Randomized and directed bench for ring_phase_monitor against a step-counting model.
module tb_ring_phase_monitor;
    localparam int N  = 4;
    localparam int LS = 3;
    localparam int RW = 4;
`ifdef STICKY_ERR_EN
    localparam int STICKY = 1;
`else
    localparam int STICKY = 0;
`endif

    logic clk = 1'b0;
    logic override_n = 1'b0;
    always #5 clk = ~clk;

    ring_phase_monitor_if #(.N(N), .ROT_W(RW)) bus ();

    ring_phase_monitor #(.N(N), .LOCK_STEPS(LS), .ROT_W(RW), .SHIFT_LEFT(1)) dut (
        .clk(clk),
        .override_n(override_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // model: legal steps since (re)acquisition; lock once LS steps have been seen
    bit         m_started, m_faulted;
    int         m_run, m_rot, m_phase;
    logic [3:0] m_prev;
    logic [3:0] last;

    function automatic logic [3:0] nxt(input logic [3:0] v);
        return 4'(((v << 1) | (v >> 3)) & 4'hF);
    endfunction

    function automatic int m_lock();
        return (m_started && !m_faulted && m_run >= LS) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_faulted = 0; m_run = 0; m_rot = 0; m_phase = 0; m_prev = 4'b0;
    endtask

    task automatic model_step(input logic [3:0] c, input bit k);
        bit oh, legal;
        oh = ($countones(c) == 1);
        legal = oh && (c == nxt(m_prev));
        if (!m_started) begin
            m_started = 1; m_faulted = !oh; m_run = 0;
        end else if (m_faulted) begin
            if (oh && (STICKY == 0 || k)) begin m_faulted = 0; m_run = 0; end
        end else if (legal) begin
            if (m_run >= LS && c[0]) m_rot = (m_rot + 1) % (1 << RW);
            if (m_run < LS) m_run++;
        end else begin
            m_faulted = 1; m_run = 0;
        end
        if (k) m_rot = 0;
        if (oh) for (int i = 0; i < N; i++) if (c[i]) m_phase = i;
        m_prev = c;
    endtask

    task automatic apply(input logic [3:0] c, input bit k);
        bus.count = c;
        bus.clr   = k;
        @(posedge clk);
        model_step(c, k);
        last = c;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("phase", int'(bus.phase), m_phase);
            check("rotations", int'(bus.rotations), m_rot);
            check("lock", int'(bus.lock), m_lock());
            check("err", int'(bus.err), m_faulted ? 1 : 0);
        end
    end

    task automatic recover(input logic [3:0] start);
        logic [3:0] c;
        c = start;
        apply(c, 1'b0);
        check("rec_err_first", int'(bus.err), STICKY);
        c = nxt(c);
        apply(c, 1'b1);
        check("rec_err_clr", int'(bus.err), 0);
        for (int j = 1; j <= 3; j++) begin
            c = nxt(c);
            apply(c, 1'b0);
            check("rec_lock", int'(bus.lock), (j >= (STICKY != 0 ? 3 : 2)) ? 1 : 0);
        end
    endtask

    task automatic mid_reset();
        #2 override_n = 1'b0;
        model_reset();
        #1;
        check("rst_phase", int'(bus.phase), 0);
        check("rst_rot", int'(bus.rotations), 0);
        check("rst_lock", int'(bus.lock), 0);
        check("rst_err", int'(bus.err), 0);
        #3 override_n = 1'b1;
    endtask

    initial begin
        logic [3:0] c;
        bit k;
        int r;
        bus.count = 4'b0;
        bus.clr   = 1'b0;
        model_reset();
        last = 4'b0;
        #12;
        check("init_phase", int'(bus.phase), 0);
        check("init_rot", int'(bus.rotations), 0);
        check("init_lock", int'(bus.lock), 0);
        check("init_err", int'(bus.err), 0);
        override_n = 1'b1;
        chk_en = 1'b1;

        apply(4'b0001, 0); apply(4'b0010, 0); apply(4'b0100, 0);
        check("t1_prelock", int'(bus.lock), 0);
        apply(4'b1000, 0);
        check("t1_lock", int'(bus.lock), 1);
        check("t1_phase", int'(bus.phase), 3);
        check("t1_err", int'(bus.err), 0);
        check("t1_rot", int'(bus.rotations), 0);

        for (int p = 0; p < 16; p++) begin
            apply(4'b0001, 0);
            check("t2_rot", int'(bus.rotations), (p + 1) % 16);
            check("t2_lock", int'(bus.lock), 1);
            apply(4'b0010, 0); apply(4'b0100, 0); apply(4'b1000, 0);
        end

        for (int p = 0; p < 5; p++) begin
            apply(4'b0001, 0); apply(4'b0010, 0); apply(4'b0100, 0); apply(4'b1000, 0);
        end
        check("t5_pre", int'(bus.rotations), 5);
        apply(4'b0001, 1);
        check("t5_clr_rot", int'(bus.rotations), 0);
        check("t5_lock", int'(bus.lock), 1);

        apply(4'b0010, 0);
        check("t3_phase1", int'(bus.phase), 1);
        apply(4'b0011, 0);
        check("t3_err", int'(bus.err), 1);
        check("t3_lock", int'(bus.lock), 0);
        check("t3_phase", int'(bus.phase), 1);
        recover(4'b0100);

        apply(4'b1000, 0); apply(4'b0001, 0);
        apply(4'b0100, 0);
        check("t4_err", int'(bus.err), 1);
        check("t4_lock", int'(bus.lock), 0);
        recover(4'b1000);

        for (int s = 0; s < 9; s++) apply(nxt(last), 0);
        mid_reset();

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 78)
                c = ($countones(last) == 1) ? nxt(last) : 4'(4'b0001 << $urandom_range(0, 3));
            else if (r < 83) c = last;
            else if (r < 88) c = nxt(nxt(last));
            else if (r < 93) c = 4'b0;
            else c = 4'($urandom_range(0, 15));
            k = ($urandom_range(0, 11) == 0);
            apply(c, k);
            if ($urandom_range(0, 399) == 0) mid_reset();
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
